// File: rtl/frogger_pkg.sv
// Shared types and default constants for the frog movement controller.
package frogger_pkg;

    // Controller states
    typedef enum logic [1:0] {
        READY = 2'd0,
        HOP   = 2'd1,
        DEAD  = 2'd2,
        HOME  = 2'd3
    } frog_state_t;

    // Hop direction latched at the start of a hop
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } frog_dir_t;

    // USB HID keycodes for the arrow-style controls
    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;

    // Playfield geometry in pixels
    localparam int GRID_PX        = 32;
    localparam int HOP_FRAMES_DEF = 4;
    localparam int X_START_PX     = 304;
    localparam int Y_START_PX     = 448;
    localparam int Y_HOME_PX      = 32;
    localparam int X_MAX_PX       = 608;
    localparam int Y_MAX_PX       = 448;

endpackage

// File: rtl/frog_controller_if.sv
// Game-logic <-> frog controller signal bundle.
interface frog_controller_if;
    logic [7:0] keycode;
    logic       hazard_hit;
    logic       respawn;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic       isDead;
    logic       isAlive;
    logic       hop_active;

    // Game logic side
    modport master (
        output keycode, hazard_hit, respawn,
        input  frog_x, frog_y, isDead, isAlive, hop_active
    );

    // Controller side
    modport slave (
        input  keycode, hazard_hit, respawn,
        output frog_x, frog_y, isDead, isAlive, hop_active
    );
endinterface

// File: rtl/frame_tick.sv
// Synchronises the vsync level into the Clk domain and emits a one-cycle
// pulse on each of its rising edges.
module frame_tick (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    logic [1:0] sync_reg;
    logic       prev_reg;

    // Two-flop synchroniser plus one delay flop for edge detection
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_reg <= 2'b00;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], frame_clk};
            prev_reg <= sync_reg[1];
        end
    end

    assign tick = sync_reg[1] & ~prev_reg;
endmodule

// File: rtl/frog_controller.sv
// Frog position / life-state controller: grid hops animated over several
// frame ticks, hazard death, home detection and respawn.
module frog_controller
    import frogger_pkg::*;
#(
    parameter int GRID       = GRID_PX,
    parameter int HOP_FRAMES = HOP_FRAMES_DEF,
    parameter int X_START    = X_START_PX,
    parameter int Y_START    = Y_START_PX,
    parameter int Y_HOME     = Y_HOME_PX,
    parameter int X_MAX      = X_MAX_PX,
    parameter int Y_MAX      = Y_MAX_PX
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    frog_controller_if.slave bus
);
    localparam logic [9:0]  STEP_PX   = 10'(GRID / HOP_FRAMES);
    localparam logic [9:0]  X_START_V = 10'(X_START);
    localparam logic [9:0]  Y_START_V = 10'(Y_START);
    localparam logic [9:0]  Y_HOME_V  = 10'(Y_HOME);
    // Bound checks run one bit wider so a target past 1023 cannot wrap
    localparam logic [10:0] GRID_W    = 11'(GRID);
    localparam logic [10:0] UP_MIN_W  = 11'(Y_HOME + GRID);
    localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
    localparam logic [10:0] Y_MAX_W   = 11'(Y_MAX);
    localparam int          CNT_W     = $clog2(HOP_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(HOP_FRAMES - 1);

    frog_state_t      state_reg, state_next;
    frog_dir_t        dir_reg, dir_next;
    logic [9:0]       x_reg, x_next, y_reg, y_next;
    logic [CNT_W-1:0] step_cnt_reg, step_cnt_next;
    logic             key_armed_reg, key_armed_next;
    logic             is_dead_reg, is_dead_next;
    logic             is_alive_reg, is_alive_next;

    logic             tick;
    logic             key_valid;
    frog_dir_t        key_dir;
    logic             in_bounds;
    logic [9:0]       x_step, y_step;
    logic [10:0]      x_w, y_w;

    frame_tick u_frame_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign x_w = {1'b0, x_reg};
    assign y_w = {1'b0, y_reg};

    // Keycode decode; anything unrecognised counts as no key
    always_comb begin
        key_valid = 1'b1;
        key_dir   = DIR_UP;
        case (bus.keycode)
            KEY_UP:    key_dir = DIR_UP;
            KEY_DOWN:  key_dir = DIR_DOWN;
            KEY_LEFT:  key_dir = DIR_LEFT;
            KEY_RIGHT: key_dir = DIR_RIGHT;
            default:   key_valid = 1'b0;
        endcase
    end

    // Whole-hop target must stay inside the playfield
    always_comb begin
        in_bounds = 1'b0;
        case (key_dir)
            DIR_UP:    in_bounds = (y_w >= UP_MIN_W);
            DIR_DOWN:  in_bounds = ((y_w + GRID_W) <= Y_MAX_W);
            DIR_LEFT:  in_bounds = (x_w >= GRID_W);
            DIR_RIGHT: in_bounds = ((x_w + GRID_W) <= X_MAX_W);
        endcase
    end

    // Position after one animation step in the latched direction
    always_comb begin
        x_step = x_reg;
        y_step = y_reg;
        case (dir_reg)
            DIR_UP:    y_step = y_reg - STEP_PX;
            DIR_DOWN:  y_step = y_reg + STEP_PX;
            DIR_LEFT:  x_step = x_reg - STEP_PX;
            DIR_RIGHT: x_step = x_reg + STEP_PX;
        endcase
    end

    // Next-state logic: respawn beats everything, then hazard, then motion
    always_comb begin
        state_next     = state_reg;
        dir_next       = dir_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        step_cnt_next  = step_cnt_reg;
        key_armed_next = key_armed_reg;
        if (bus.respawn) begin
            state_next     = READY;
            x_next         = X_START_V;
            y_next         = Y_START_V;
            step_cnt_next  = '0;
            key_armed_next = 1'b0;
        end else if (tick) begin
            if ((state_reg == READY || state_reg == HOP) && bus.keycode == KEY_NONE)
                key_armed_next = 1'b1;
            case (state_reg)
                READY: begin
                    if (bus.hazard_hit) begin
                        state_next = DEAD;
                    end else if (key_valid && key_armed_reg && in_bounds) begin
                        state_next     = HOP;
                        dir_next       = key_dir;
                        key_armed_next = 1'b0;
                        step_cnt_next  = '0;
                    end
                end
                HOP: begin
                    // The step of the tick that reports the hazard still lands;
                    // the frog is frozen from then on.
                    x_next        = x_step;
                    y_next        = y_step;
                    step_cnt_next = step_cnt_reg + 1'b1;
                    if (bus.hazard_hit)
                        state_next = DEAD;
                    else if (step_cnt_reg == LAST_STEP)
                        state_next = (y_step == Y_HOME_V) ? HOME : READY;
                end
                default: ;
            endcase
        end
        is_dead_next  = (state_reg == DEAD) && !bus.respawn;
        is_alive_next = (state_reg == HOME) && !bus.respawn;
    end

    // State and position registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= READY;
            dir_reg       <= DIR_UP;
            x_reg         <= X_START_V;
            y_reg         <= Y_START_V;
            step_cnt_reg  <= '0;
            key_armed_reg <= 1'b0;
            is_dead_reg   <= 1'b0;
            is_alive_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dir_reg       <= dir_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            step_cnt_reg  <= step_cnt_next;
            key_armed_reg <= key_armed_next;
            is_dead_reg   <= is_dead_next;
            is_alive_reg  <= is_alive_next;
        end
    end

    assign bus.frog_x     = x_reg;
    assign bus.frog_y     = y_reg;
    assign bus.isDead     = is_dead_reg;
    assign bus.isAlive    = is_alive_reg;
    assign bus.hop_active = (state_reg == HOP);
endmodule

// File: doc/frog_controller.md
FROG_CONTROLLER -- requirements
Module: frog_controller

Interface
REQ-001 SHALL have parameter GRID, default 32, meaning hop distance in pixels.
REQ-002 SHALL have parameter HOP_FRAMES, default 4, meaning frame ticks per hop; GRID SHALL be divisible by HOP_FRAMES.
REQ-003 SHALL have parameters X_START 304, Y_START 448, Y_HOME 32, X_MAX 608, Y_MAX 448, meaning spawn, home row and bounds in pixels (minimum X = 0, minimum Y = Y_HOME).
REQ-004 SHALL have port Clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port frame_clk, input, 1, meaning vertical-sync level, sampled as data in the Clk domain (not a clock).
REQ-007 SHALL have port keycode, input, 8, meaning current USB keycode; 0x1A up, 0x16 down, 0x04 left, 0x07 right, 0x00 none.
REQ-008 SHALL have port hazard_hit, input, 1, meaning the frog overlaps a car or water this frame.
REQ-009 SHALL have port respawn, input, 1, meaning a one-Clk pulse from game logic that returns the frog to spawn.
REQ-010 SHALL have ports frog_x and frog_y, output, 10 each, meaning frog top-left pixel position.
REQ-011 SHALL have ports isDead and isAlive, output, 1 each, meaning status levels consumed by game logic.
REQ-012 SHALL have port hop_active, output, 1, meaning a hop is in progress.

Function
REQ-013 SHALL generate frame_tick, a one-Clk pulse on each rising edge of a 2-flop-synchronised frame_clk; all motion and hazard sampling SHALL occur only on frame_tick.
REQ-014 SHALL implement states READY, HOP, DEAD, HOME.
REQ-015 READY: on frame_tick, hazard_hit=1 -> DEAD; otherwise a valid direction key with key_armed=1 whose target lies in bounds -> HOP (latch direction, clear key_armed, step_cnt=0).
REQ-016 A key whose target is out of bounds SHALL be ignored: no state change, key_armed unchanged.
REQ-017 key_armed SHALL set when keycode==0x00 is sampled; one physical press SHALL produce at most one hop.
REQ-018 Unrecognised nonzero keycodes SHALL be treated as no key and SHALL NOT set key_armed.
REQ-019 HOP: each frame_tick moves the frog GRID/HOP_FRAMES pixels in the latched direction and increments step_cnt; on tick HOP_FRAMES the position SHALL equal the start plus or minus GRID exactly.
REQ-020 At the end of a hop: if frog_y==Y_HOME -> HOME, else -> READY.
REQ-021 hazard_hit=1 on any frame_tick in HOP SHALL go to DEAD, freezing the position at its current value; on the final hop tick hazard SHALL take priority over HOME.
REQ-022 DEAD: isDead=1, position frozen, keys ignored. HOME: isAlive=1, position frozen, keys ignored.
REQ-023 respawn=1 in any state SHALL, on the next Clk edge, set position to (X_START, Y_START), state READY, isDead=0, isAlive=0, key_armed=0.
REQ-024 Priority SHALL be Reset > respawn > hazard_hit > movement; respawn coincident with frame_tick SHALL suppress that tick's motion.
REQ-025 isDead and isAlive SHALL be registered, mutually exclusive, and asserted one Clk after entering DEAD or HOME respectively.
REQ-026 hop_active SHALL equal (state==HOP).
REQ-027 Position arithmetic SHALL be 10-bit unsigned; bound checks SHALL prevent underflow and wrap.

Reset
REQ-028 On Reset, state SHALL be READY, frog_x=X_START, frog_y=Y_START, isDead=0, isAlive=0, hop_active=0, step_cnt=0, key_armed=0, and synchroniser flops=0.
REQ-029 Reset asserted mid-hop SHALL abort the hop immediately and asynchronously.

Structure
REQ-030 Package frogger_pkg SHALL hold the frog_state_t enum, keycode constants, and grid/spawn/bound constants that the parameters default from.
REQ-031 Sub-module frame_tick SHALL contain the synchroniser and rising-edge detector.

Verification
REQ-032 Reset, then keycode=0x1A held for 5 ticks -> exactly zero hops (key_armed=0 after reset); release, press 0x1A -> frog_y moves 448->440->432->424->416 over 4 ticks, then READY.
REQ-033 At frog_x=608, press 0x07 -> no hop, hop_active=0, frog_x stays 608.
REQ-034 Hazard_hit=1 on the 2nd tick of an up hop from y=448 -> DEAD at y=432, isDead=1 the next Clk; respawn pulse -> (304,448), isDead=0.
REQ-035 Hop from y=64 to y=32 with hazard_hit=0 -> HOME, isAlive=1; hazard_hit=1 on the final tick instead -> DEAD, isAlive stays 0.
REQ-036 Respawn asserted on the same Clk as frame_tick mid-hop -> position (304,448), READY, no motion that tick.
REQ-037 Reset asserted mid-hop -> all outputs at reset values before the next Clk edge.
